imm_encoder: RTL and testbench

- Inverse of the core's immediate generator: packs register fields and a 32-bit immediate into one RV32I instruction word.
- Range-checks the immediate for the selected format; an illegal immediate is reported, never encoded.
- Emits encoded words on a valid/ready stream with an auto-incrementing word address.
- Used by the test/boot path to write programs into instruction memory.

---
 rtl/imm_encoder.sv | 116 +++++++++++
 tb/tb_imm_encoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// RV32I instruction packer: register fields plus immediate in, one word out.
// Illegal immediates are counted and flagged, never emitted.
module imm_encoder #(
    parameter int unsigned           ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
    parameter int unsigned           ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           Imm_Ctrl,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          Immediate,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 err_valid,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_J = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_R = 3'd5;

    logic [31:0] enc;
    logic        legal;
    logic        accept;
    logic        drain;

    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_comb begin
        enc   = '0;
        legal = 1'b0;
        case (Imm_Ctrl)
            FMT_I: begin
                enc   = {Immediate[11:0], rs1, funct3, rd, opcode};
                legal = (&Immediate[31:11]) || !(|Immediate[31:11]);
            end
            FMT_S: begin
                enc   = {Immediate[11:5], rs2, rs1, funct3,
                         Immediate[4:0], opcode};
                legal = (&Immediate[31:11]) || !(|Immediate[31:11]);
            end
            FMT_B: begin
                enc   = {Immediate[12], Immediate[10:5], rs2, rs1, funct3,
                         Immediate[4:1], Immediate[11], opcode};
                legal = ((&Immediate[31:12]) || !(|Immediate[31:12]))
                        && !Immediate[0];
            end
            FMT_J: begin
                enc   = {Immediate[20], Immediate[10:1], Immediate[11],
                         Immediate[19:12], rd, opcode};
                legal = ((&Immediate[31:20]) || !(|Immediate[31:20]))
                        && !Immediate[0];
            end
            FMT_U: begin
                enc   = {Immediate[31:12], rd, opcode};
                legal = !(|Immediate[11:0]);
            end
            FMT_R: begin
                enc   = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            default: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            err_valid <= 1'b0;
            err_cnt   <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_addr  <= BASE_ADDR;
            err_valid <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_valid <= 1'b0;
            if (drain) begin
                out_valid <= 1'b0;
                out_addr  <= out_addr + ADDR_W'(4);
            end
            // A rejected request leaves the output register alone
            if (accept && legal) begin
                out_valid <= 1'b1;
                out_instr <= enc;
            end
            if (accept && !legal) begin
                err_valid <= 1'b1;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized checks for imm_encoder.
// Round-trips every legal word through a reference immediate decoder.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  Imm_Ctrl;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] Immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_valid;
    logic [7:0]  err_cnt;

    int total = 0;
    int passed = 0;

    imm_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .Imm_Ctrl(Imm_Ctrl), .opcode(opcode), .rd(rd), .rs1(rs1),
        .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .Immediate(Immediate), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_valid(err_valid), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  ctrl;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] instr;
    } vec_t;

    vec_t vt[16];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(vec_t v);
        Imm_Ctrl  = v.ctrl;
        opcode    = v.op;
        rd        = v.rd;
        rs1       = v.rs1;
        rs2       = v.rs2;
        funct3    = v.f3;
        funct7    = v.f7;
        Immediate = v.imm;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic logic [31:0] dec_imm(logic [2:0] c, logic [31:0] i);
        case (c)
            3'd0: return {{20{i[31]}}, i[31:20]};
            3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4: return {i[31:12], 12'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic rt_ok(vec_t v, logic [31:0] i);
        logic ok;
        ok = (i[6:0] == v.op);
        if (v.ctrl != 3'd5) ok = ok && (dec_imm(v.ctrl, i) == v.imm);
        if (v.ctrl inside {3'd0, 3'd3, 3'd4, 3'd5}) ok = ok && (i[11:7] == v.rd);
        if (v.ctrl inside {3'd0, 3'd1, 3'd2, 3'd5}) ok = ok && (i[19:15] == v.rs1);
        if (v.ctrl inside {3'd1, 3'd2, 3'd5}) ok = ok && (i[24:20] == v.rs2);
        if (v.ctrl != 3'd3 && v.ctrl != 3'd4) ok = ok && (i[14:12] == v.f3);
        if (v.ctrl == 3'd5) ok = ok && (i[31:25] == v.f7);
        return ok;
    endfunction

    initial begin
        vec_t        v;
        logic [31:0] ea;
        logic [31:0] ec;
        logic        mv;
        logic [31:0] mq;
        logic [31:0] maddr;
        logic        er;
        int          k;
        int          got;

        vt[0]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b1, 32'hFFF00093};
        vt[1]  = '{3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3};
        vt[2]  = '{3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00001002, 1'b0, 32'h0};
        vt[3]  = '{3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 1'b1, 32'h001000EF};
        vt[4]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b1, 32'h123452B7};
        vt[5]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 1'b0, 32'h0};
        vt[6]  = '{3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 1'b1, 32'h002081B3};
        vt[7]  = '{3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h00000008, 1'b1, 32'h0020A423};
        vt[8]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 1'b0, 32'h0};
        vt[9]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000007FF, 1'b1, 32'h7FF00093};
        vt[10] = '{3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000003, 1'b0, 32'h0};
        vt[11] = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 32'h0};
        vt[12] = '{3'd3, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 1'b1, 32'h8000006F};
        vt[13] = '{3'd3, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 1'b0, 32'h0};
        vt[14] = '{3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFFFFF, 1'b1, 32'hFE20AFA3};
        vt[15] = '{3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 1'b1, 32'h402081B3};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(vt[0]);
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // Directed vectors, one request then one idle drain cycle each
        ea = 32'h0; ec = 32'h0;
        for (int i = 0; i < 16; i++) begin
            drive(vt[i]);
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            if (vt[i].legal) begin
                chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d_out_instr", i), out_instr, vt[i].instr);
                chk($sformatf("v%0d_out_addr", i), out_addr, ea);
                chk($sformatf("v%0d_err_valid", i), 32'(err_valid), 32'd0);
                ea = ea + 4;
            end else begin
                ec = ec + 1;
                chk($sformatf("v%0d_err_valid", i), 32'(err_valid), 32'd1);
                chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd0);
                chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), ec);
                chk($sformatf("v%0d_out_addr", i), out_addr, ea);
            end
            tick();
            chk($sformatf("v%0d_idle_err", i), 32'(err_valid), 32'd0);
        end
        chk("addr_after_table", out_addr, ea);

        // Back-to-back with out_ready toggling 1010...
        pulse_clear();
        mv = 1'b0; mq = 32'h0; maddr = 32'h0; k = 0; got = 0;
        for (int c = 0; c < 100 && got < 8; c++) begin
            out_ready = (c % 2 == 0);
            if (k < 8) begin
                v = '{3'd0, 7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'h00, 32'(k + 1), 1'b1, 32'h0};
                drive(v);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'(mv));
            if (mv) begin
                chk("bp_out_instr", out_instr, mq);
                chk("bp_out_addr", out_addr, maddr);
            end
            er = !mv || out_ready;
            chk("bp_in_ready", 32'(in_ready), 32'(er));
            if (mv && out_ready) begin
                got++;
                maddr = maddr + 4;
                mv = 1'b0;
            end
            if (in_valid && er) begin
                mv = 1'b1;
                mq = (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13;
                k++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("bp_words_consumed", 32'(got), 32'd8);
        chk("bp_final_addr", maddr, 32'h20);

        // Saturating error counter
        pulse_clear();
        v = '{3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b0, 32'h0};
        drive(v);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);
        chk("sat_err_valid", 32'(err_valid), 32'd1);
        chk("sat_out_valid", 32'(out_valid), 32'd0);
        chk("sat_out_addr", out_addr, 32'h0);

        // Pending word, then clear with a competing request
        drive(vt[0]);
        out_ready = 1'b0;
        tick();
        chk("pend_out_valid", 32'(out_valid), 32'd1);
        chk("pend_out_instr", out_instr, 32'hFFF00093);
        clear = 1'b1;
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_err_valid", 32'(err_valid), 32'd0);
        chk("clr_out_addr", out_addr, 32'h0);

        // Reset while a word is pending
        drive(vt[4]);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("mid_out_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_instr", out_instr, 32'h0);
        chk("mid_rst_out_addr", out_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Random legal round trip, one request per cycle
        ea = 32'h0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            v.ctrl = 3'($urandom_range(0, 5));
            v.op   = 7'($urandom);
            v.rd   = 5'($urandom);
            v.rs1  = 5'($urandom);
            v.rs2  = 5'($urandom);
            v.f3   = 3'($urandom);
            v.f7   = 7'($urandom);
            v.imm  = $urandom;
            case (v.ctrl)
                3'd0, 3'd1: v.imm = {{20{v.imm[11]}}, v.imm[11:0]};
                3'd2:       v.imm = {{19{v.imm[12]}}, v.imm[12:1], 1'b0};
                3'd3:       v.imm = {{11{v.imm[20]}}, v.imm[20:1], 1'b0};
                3'd4:       v.imm = {v.imm[31:12], 12'h0};
                default:    v.imm = v.imm;
            endcase
            drive(v);
            tick();
            total++;
            if (out_valid && !err_valid && rt_ok(v, out_instr) && out_addr == ea)
                passed++;
            else
                $display("FAIL roundtrip: got instr %h addr %h valid %b for ctrl %0d imm %h, required addr %h",
                         out_instr, out_addr, out_valid, v.ctrl, v.imm, ea);
            ea = ea + 4;
        end
        in_valid = 1'b0;
        tick();
        chk("rt_final_addr", out_addr, ea);
        chk("rt_err_cnt", 32'(err_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
